decode: RTL
===========

// Module: decode
// PURPOSE
// - RV32I decode stage; sits directly downstream of the fetch stage and consumes its INSTR/VALID pair.
// - Registers the instruction's PC, register indices, funct fields and the sign-extended immediate into a
//   single pipeline register for the execute stage; flags illegal encodings.
// - Uses the VALID/STALLED/NEXT_STALLED/HALT pipeline-flow protocol; adds FLUSH for branch redirect.
// PARAMETERS
// - ENABLE_M  default 0   1: OP (0110011) with funct7=0000001 is legal (RV32M); 0: illegal
// - CNT_W     default 32  width of DECODE_COUNT
// PORTS
// - CLK           in   1      clock; all state updates on posedge
// - RSTN          in   1      reset, synchronous, active-high (1 = reset)
// - PC_IN         in   32     PC of INSTR_IN
// - INSTR_IN      in   32     instruction word from fetch
// - PREV_VALID    in   1      fetch output valid
// - HALT          in   1      local stall request
// - NEXT_STALLED  in   1      execute stage stalled
// - FLUSH         in   1      kill the instruction held in this stage
// - STALLED       out  1      combinational: NEXT_STALLED | HALT; fed back to fetch NEXT_STALLED
// - VALID         out  1      decoded outputs valid
// - PC_OUT        out  32     registered PC
// - OPCODE        out  7      INSTR[6:0]
// - RD/RS1/RS2    out  5 each INSTR[11:7]/[19:15]/[24:20]; RD forced 0 when the format has no rd (S,B) or ILLEGAL
// - FUNCT3        out  3      INSTR[14:12]
// - FUNCT7        out  7      INSTR[31:25]
// - IMM           out  32     sign-extended immediate (I/S/B/U/J); 0 for R-type
// - ILLEGAL       out  1      held instruction is not a legal RV32I(+M) encoding
// - DECODE_COUNT  out  CNT_W  valid instructions accepted since reset
// BEHAVIOUR
// - Reset (RSTN=1 at posedge): VALID=0, ILLEGAL=0, DECODE_COUNT=0, PC_OUT=0, OPCODE/RD/RS1/RS2/FUNCT3/FUNCT7/IMM=0.
// - Priority per edge: reset > FLUSH > STALLED hold > capture.
// - Capture (!STALLED, !FLUSH): VALID<=PREV_VALID; all fields are loaded from INSTR_IN/PC_IN even when
//   PREV_VALID=0 (don't-care contents). Latency: 1 cycle, INSTR_IN at edge N -> outputs after edge N.
// - STALLED=1, !FLUSH: every output register holds, including VALID; fetch stalls the same cycle via STALLED.
// - FLUSH=1: VALID<=0 regardless of STALLED; other fields hold; no count.
// - Immediates: I {{20{i[31]}},i[31:20]}; S {{20{i[31]}},i[31:25],i[11:7]};
//   B {{19{i[31]}},i[31],i[7],i[30:25],i[11:8],1'b0}; U {i[31:12],12'b0};
//   J {{11{i[31]}},i[31],i[19:12],i[20],i[30:21],1'b0}.
// - Formats: LUI/AUIPC=U; JAL=J; JALR/LOAD/OP-IMM/SYSTEM/MISC-MEM=I; STORE=S; BRANCH=B; OP=R.
// - ILLEGAL=1 when: i[1:0]!=11; opcode not in the set above; BRANCH funct3 010/011; LOAD funct3 011/110/111;
//   STORE funct3 >=011; JALR funct3!=0; OP funct7 not 0000000 (or 0100000 only with funct3 000/101;
//   0000001 only if ENABLE_M); OP-IMM SLLI funct7!=0, or SRLI/SRAI funct7 not 0000000/0100000.
// - ILLEGAL instructions still pass with VALID=1; RD=0, IMM=0 so execute raises the trap.
// - DECODE_COUNT += 1 on capture with PREV_VALID=1 and !FLUSH; wraps modulo 2^CNT_W.
// - Reset asserted mid-stall or mid-flush: the reset values win; VALID=0 on the next cycle.
// TESTING
// - Reset then PREV_VALID=1, INSTR_IN=0x00500093 (addi x1,x0,5), PC_IN=0x10 -> next cycle VALID=1, RD=1, RS1=0,
//   IMM=5, PC_OUT=0x10, DECODE_COUNT=1.
// - INSTR_IN=0xFE000EE3 (beq x0,x0,-4) -> IMM=0xFFFFFFFC, RD=0, ILLEGAL=0; 0x800000EF (jal) -> IMM=0xFFF00000.
// - Hold addi, NEXT_STALLED=1 for 3 cycles while INSTR_IN changes -> STALLED=1 same cycle, outputs and count frozen;
//   release -> new instruction captured on the next edge.
// - FLUSH=1 with NEXT_STALLED=1 and VALID=1 -> VALID=0 after the edge, count unchanged; FLUSH with RSTN=1 -> reset values.
// - ENABLE_M=0, INSTR_IN=0x02208033 (mul) -> VALID=1, ILLEGAL=1, RD=0; ENABLE_M=1 -> ILLEGAL=0, RD=0;
//   INSTR_IN=0x00000000 -> ILLEGAL=1.
// - CNT_W=4, 17 valid captures -> DECODE_COUNT=1 (wrap).

Source files
------------

// File: rtl/decode.sv
// decode: RV32I decode stage sitting between fetch and execute.
//   Captures the PC, register indices, funct fields and the sign-extended
//   immediate of the fetched instruction into one pipeline register and
//   flags encodings that are not legal RV32I (or RV32M when ENABLE_M=1).
// Ports:
//   CLK, RSTN        clock, synchronous active-high reset
//   PC_IN, INSTR_IN  instruction and its PC from fetch
//   PREV_VALID       fetch output valid
//   HALT             local stall request
//   NEXT_STALLED     execute stage stalled
//   FLUSH            kill the instruction held here (branch redirect)
//   STALLED          NEXT_STALLED | HALT, back to fetch
//   VALID            registered outputs hold a live instruction
//   PC_OUT, OPCODE, RD, RS1, RS2, FUNCT3, FUNCT7, IMM, ILLEGAL  decoded fields
//   DECODE_COUNT     valid instructions accepted since reset
module decode #(
  parameter int ENABLE_M = 0,
  parameter int CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [31:0]      PC_IN,
  input  logic [31:0]      INSTR_IN,
  input  logic             PREV_VALID,
  input  logic             HALT,
  input  logic             NEXT_STALLED,
  input  logic             FLUSH,
  output logic             STALLED,
  output logic             VALID,
  output logic [31:0]      PC_OUT,
  output logic [6:0]       OPCODE,
  output logic [4:0]       RD,
  output logic [4:0]       RS1,
  output logic [4:0]       RS2,
  output logic [2:0]       FUNCT3,
  output logic [6:0]       FUNCT7,
  output logic [31:0]      IMM,
  output logic             ILLEGAL,
  output logic [CNT_W-1:0] DECODE_COUNT
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        ill;
  } dec_t;

  logic [31:0] i;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [31:0] imm_raw;
  logic        has_rd, ill;
  dec_t        dec_d, dec_q;
  logic        vld_q;
  logic [CNT_W-1:0] cnt_q;

  assign i   = INSTR_IN;
  assign opc = i[6:0];
  assign f3  = i[14:12];
  assign f7  = i[31:25];

  assign STALLED = NEXT_STALLED | HALT;

  always_comb begin
    imm_raw = '0;
    has_rd  = 1'b1;
    ill     = 1'b0;
    case (opc)
      OP_LUI, OP_AUIPC: imm_raw = {i[31:12], 12'b0};
      OP_JAL:  imm_raw = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      OP_JALR: begin
        imm_raw = {{20{i[31]}}, i[31:20]};
        ill     = (f3 != 3'b000);
      end
      OP_LOAD: begin
        imm_raw = {{20{i[31]}}, i[31:20]};
        ill     = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OP_OPIMM: begin
        imm_raw = {{20{i[31]}}, i[31:20]};
        // shift-immediates reuse imm[11:5] as a funct7 qualifier
        if (f3 == 3'b001)
          ill = (f7 != 7'b0000000);
        else if (f3 == 3'b101)
          ill = (f7 != 7'b0000000) && (f7 != 7'b0100000);
      end
      OP_MISC, OP_SYSTEM: imm_raw = {{20{i[31]}}, i[31:20]};
      OP_STORE: begin
        imm_raw = {{20{i[31]}}, i[31:25], i[11:7]};
        has_rd  = 1'b0;
        ill     = (f3 > 3'b010);
      end
      OP_BRANCH: begin
        imm_raw = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        has_rd  = 1'b0;
        ill     = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OP_OP: begin
        case (f7)
          7'b0000000: ill = 1'b0;
          7'b0100000: ill = !((f3 == 3'b000) || (f3 == 3'b101));
          7'b0000001: ill = (ENABLE_M == 0);
          default:    ill = 1'b1;
        endcase
      end
      // opcode already carries i[1:0], so non-32-bit encodings land here too
      default: ill = 1'b1;
    endcase
  end

  always_comb begin
    dec_d     = '0;
    dec_d.pc  = PC_IN;
    dec_d.op  = opc;
    dec_d.rd  = (has_rd && !ill) ? i[11:7] : 5'd0;
    dec_d.rs1 = i[19:15];
    dec_d.rs2 = i[24:20];
    dec_d.f3  = f3;
    dec_d.f7  = f7;
    dec_d.imm = ill ? 32'd0 : imm_raw;
    dec_d.ill = ill;
  end

  always_ff @(posedge CLK) begin
    if (RSTN) begin
      vld_q <= 1'b0;
      dec_q <= '0;
      cnt_q <= '0;
    end else if (FLUSH) begin
      vld_q <= 1'b0;
    end else if (!STALLED) begin
      vld_q <= PREV_VALID;
      dec_q <= dec_d;
      if (PREV_VALID) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign VALID        = vld_q;
  assign PC_OUT       = dec_q.pc;
  assign OPCODE       = dec_q.op;
  assign RD           = dec_q.rd;
  assign RS1          = dec_q.rs1;
  assign RS2          = dec_q.rs2;
  assign FUNCT3       = dec_q.f3;
  assign FUNCT7       = dec_q.f7;
  assign IMM          = dec_q.imm;
  assign ILLEGAL      = dec_q.ill;
  assign DECODE_COUNT = cnt_q;
endmodule
